// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard / stall controller:
//   - register-address and wait-timer widths
//   - memory-wait FSM state encoding
//   - pipeline-control bundle driven to the PC and pipeline registers
//   - canned control bundles for each decode outcome
//   - source-operand match helper used by the load-use check

package hazard_ctrl_pkg;

   localparam int unsigned REG_ADDR_WIDTH = 5;
   localparam int unsigned TIMER_WIDTH    = 16;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StError   = 2'd2
   } state_t;

   typedef struct packed {
      logic pc_write;
      logic IFID_write;
      logic IF_flush;
      logic ID_flush;
      logic freeze;
   } pipe_ctrl_t;

   // Normal advance; also the forced decode while rst is high.
   localparam pipe_ctrl_t CTRL_ADVANCE = '{
      pc_write:   1'b1,
      IFID_write: 1'b1,
      IF_flush:   1'b0,
      ID_flush:   1'b0,
      freeze:     1'b0
   };

   // Whole pipeline held while data memory is busy or after a timeout.
   localparam pipe_ctrl_t CTRL_FREEZE = '{
      pc_write:   1'b0,
      IFID_write: 1'b0,
      IF_flush:   1'b0,
      ID_flush:   1'b0,
      freeze:     1'b1
   };

   // Taken branch: squash IF/ID and ID/EX, let the PC load the target.
   localparam pipe_ctrl_t CTRL_BRANCH = '{
      pc_write:   1'b1,
      IFID_write: 1'b1,
      IF_flush:   1'b1,
      ID_flush:   1'b1,
      freeze:     1'b0
   };

   // Load-use: hold PC and IF/ID, drop a bubble into ID/EX.
   localparam pipe_ctrl_t CTRL_LOAD_USE = '{
      pc_write:   1'b0,
      IFID_write: 1'b0,
      IF_flush:   1'b0,
      ID_flush:   1'b1,
      freeze:     1'b0
   };

   // True when an operand that is actually read matches the destination.
   function automatic logic src_match(input logic                      use_src,
                                      input logic [REG_ADDR_WIDTH-1:0] rs,
                                      input logic [REG_ADDR_WIDTH-1:0] rd);
      return use_src && (rs == rd);
   endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter
//   Saturating up-counter. Counts one per cycle while inc is high and
//   sticks at all-ones instead of wrapping. clr has priority over inc.
//
//   Ports
//     clk   : rising-edge clock
//     clr   : synchronous clear to zero
//     inc   : add one this cycle (ignored once saturated)
//     count : current value

module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] MAX_VAL = '1;

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc && (count != MAX_VAL)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard and stall controller. Each cycle it decides whether the
//   pipeline advances, stalls for a load-use dependency, flushes for a taken
//   branch, or freezes while data memory is busy. A small FSM tracks how long
//   memory has been stalling and latches a sticky error after MEM_TIMEOUT
//   wait cycles. Three saturating counters record stalls, flushes and waits.
//
//   Parameters
//     CNT_WIDTH   : width of each performance counter
//     MEM_TIMEOUT : wait-timer value at which a continuing stall becomes an
//                   error (1 .. 2^16-1)
//
//   Ports
//     clk, rst          : clock, synchronous active-high reset
//     IFID_rs1/rs2      : source registers of the instruction in ID
//     IFID_use_rs1/rs2  : that instruction actually reads rs1 / rs2
//     IDEX_rd           : destination of the instruction in EX
//     IDEX_MemRead      : the instruction in EX is a load
//     EX_branch_taken   : branch/jump resolved taken in EX
//     mem_req/mem_ready : MEM-stage data-memory handshake
//     pc_write          : PC update enable
//     IFID_write        : IF/ID load enable
//     IF_flush          : clear IF/ID
//     ID_flush          : clear ID/EX (bubble)
//     freeze            : hold ID/EX, EX/MEM, MEM/WB
//     mem_err           : sticky memory-timeout error
//     stall_cnt         : load-use stall cycles
//     flush_cnt         : branch-flush events
//     wait_cnt          : memory-wait cycles (excluding the error state)

module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned CNT_WIDTH   = 16,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_ADDR_WIDTH-1:0] IFID_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] IFID_rs2,
   input  logic                      IFID_use_rs1,
   input  logic                      IFID_use_rs2,
   input  logic [REG_ADDR_WIDTH-1:0] IDEX_rd,
   input  logic                      IDEX_MemRead,
   input  logic                      EX_branch_taken,
   input  logic                      mem_req,
   input  logic                      mem_ready,
   output logic                      pc_write,
   output logic                      IFID_write,
   output logic                      IF_flush,
   output logic                      ID_flush,
   output logic                      freeze,
   output logic                      mem_err,
   output logic [CNT_WIDTH-1:0]      stall_cnt,
   output logic [CNT_WIDTH-1:0]      flush_cnt,
   output logic [CNT_WIDTH-1:0]      wait_cnt
);

   localparam logic [TIMER_WIDTH-1:0] TIMEOUT_VAL = TIMER_WIDTH'(MEM_TIMEOUT);

   state_t                 state_q;
   logic [TIMER_WIDTH-1:0] timer_q;

   logic       lu_hazard;
   logic       mem_stall;
   pipe_ctrl_t ctrl;
   logic       stall_inc;
   logic       flush_inc;
   logic       wait_inc;

   // ------------------------------------------------------------------
   // Condition terms
   // ------------------------------------------------------------------

   // x0 is hard-wired zero, so a load targeting it never creates a hazard.
   assign lu_hazard = IDEX_MemRead && (IDEX_rd != '0) &&
                      (src_match(IFID_use_rs1, IFID_rs1, IDEX_rd) ||
                       src_match(IFID_use_rs2, IFID_rs2, IDEX_rd));

   // A request completed in the same cycle is not a stall.
   assign mem_stall = mem_req && !mem_ready;

   // ------------------------------------------------------------------
   // Output decode: freeze > branch > load-use > advance
   // ------------------------------------------------------------------
   always_comb begin
      ctrl      = CTRL_ADVANCE;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      if (rst) begin
         ctrl = CTRL_ADVANCE;
      end else if (mem_stall || (state_q == StError)) begin
         // Branch and hazard inputs are ignored here; EX and ID are held,
         // so they are presented again once the freeze lifts.
         ctrl = CTRL_FREEZE;
      end else if (EX_branch_taken) begin
         // Overrides load-use: the dependent instruction is squashed anyway.
         ctrl      = CTRL_BRANCH;
         flush_inc = 1'b1;
      end else if (lu_hazard) begin
         ctrl      = CTRL_LOAD_USE;
         stall_inc = 1'b1;
      end
   end

   assign pc_write   = ctrl.pc_write;
   assign IFID_write = ctrl.IFID_write;
   assign IF_flush   = ctrl.IF_flush;
   assign ID_flush   = ctrl.ID_flush;
   assign freeze     = ctrl.freeze;

   // Cycles spent frozen in the error state are not memory waits.
   assign wait_inc = ctrl.freeze && (state_q != StError);

   // ------------------------------------------------------------------
   // Memory-wait FSM with timeout
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         timer_q <= '0;
         mem_err <= 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (mem_stall) begin
                  state_q <= StMemWait;
                  timer_q <= TIMER_WIDTH'(1);
               end
            end
            StMemWait: begin
               if (!mem_stall) begin
                  // Either memory answered or the request was withdrawn.
                  state_q <= StRun;
                  timer_q <= '0;
               end else if (timer_q == TIMEOUT_VAL) begin
                  state_q <= StError;
                  mem_err <= 1'b1;
               end else begin
                  timer_q <= timer_q + TIMER_WIDTH'(1);
               end
            end
            StError: begin
               // Terminal until reset.
               state_q <= StError;
            end
            default: begin
               state_q <= StRun;
               timer_q <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------
   sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_stall_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_flush_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (flush_inc),
      .count (flush_cnt)
   );

   sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_wait_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (wait_inc),
      .count (wait_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Directed scenarios with literal expectations, followed by randomized
//   stimulus, all continuously compared against a behavioural model.

module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   localparam int unsigned CW   = 4;
   localparam int unsigned TO   = 4;
   localparam int unsigned CMAX = (1 << CW) - 1;

   logic                      clk = 1'b0;
   logic                      rst = 1'b1;
   logic [REG_ADDR_WIDTH-1:0] IFID_rs1 = '0;
   logic [REG_ADDR_WIDTH-1:0] IFID_rs2 = '0;
   logic                      IFID_use_rs1 = 1'b0;
   logic                      IFID_use_rs2 = 1'b0;
   logic [REG_ADDR_WIDTH-1:0] IDEX_rd = '0;
   logic                      IDEX_MemRead = 1'b0;
   logic                      EX_branch_taken = 1'b0;
   logic                      mem_req = 1'b0;
   logic                      mem_ready = 1'b0;
   logic                      pc_write;
   logic                      IFID_write;
   logic                      IF_flush;
   logic                      ID_flush;
   logic                      freeze;
   logic                      mem_err;
   logic [CW-1:0]             stall_cnt;
   logic [CW-1:0]             flush_cnt;
   logic [CW-1:0]             wait_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .CNT_WIDTH   (CW),
      .MEM_TIMEOUT (TO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .IFID_rs1        (IFID_rs1),
      .IFID_rs2        (IFID_rs2),
      .IFID_use_rs1    (IFID_use_rs1),
      .IFID_use_rs2    (IFID_use_rs2),
      .IDEX_rd         (IDEX_rd),
      .IDEX_MemRead    (IDEX_MemRead),
      .EX_branch_taken (EX_branch_taken),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .pc_write        (pc_write),
      .IFID_write      (IFID_write),
      .IF_flush        (IF_flush),
      .ID_flush        (ID_flush),
      .freeze          (freeze),
      .mem_err         (mem_err),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt),
      .wait_cnt        (wait_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model. Error is reached on the (TO+1)-th consecutive
   // stalled cycle; once in error the block freezes until reset.
   // ------------------------------------------------------------------
   bit m_valid = 1'b0;
   bit m_err   = 1'b0;
   int m_run   = 0;
   int m_stall = 0;
   int m_flush = 0;
   int m_wait  = 0;

   bit e_lu;
   bit e_ms;
   int e_mode;  // 0 advance, 1 freeze, 2 branch, 3 load-use, 4 reset

   function automatic int sat_inc(input int v);
      return (v >= int'(CMAX)) ? int'(CMAX) : v + 1;
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         e_lu = IDEX_MemRead && (IDEX_rd != 0) &&
                ((IFID_use_rs1 && IFID_rs1 == IDEX_rd) ||
                 (IFID_use_rs2 && IFID_rs2 == IDEX_rd));
         e_ms = mem_req && !mem_ready;
         if (rst)                 e_mode = 4;
         else if (e_ms || m_err)  e_mode = 1;
         else if (EX_branch_taken) e_mode = 2;
         else if (e_lu)           e_mode = 3;
         else                     e_mode = 0;

         if (m_valid) begin
            check("model pc_write",   32'(pc_write),   32'(e_mode == 0 || e_mode == 2 || e_mode == 4));
            check("model IFID_write", 32'(IFID_write), 32'(e_mode == 0 || e_mode == 2 || e_mode == 4));
            check("model IF_flush",   32'(IF_flush),   32'(e_mode == 2));
            check("model ID_flush",   32'(ID_flush),   32'(e_mode == 2 || e_mode == 3));
            check("model freeze",     32'(freeze),     32'(e_mode == 1));
            check("model mem_err",    32'(mem_err),    32'(m_err));
            check("model stall_cnt",  32'(stall_cnt),  32'(m_stall));
            check("model flush_cnt",  32'(flush_cnt),  32'(m_flush));
            check("model wait_cnt",   32'(wait_cnt),   32'(m_wait));
         end

         // Advance the model to what the next rising edge will produce.
         if (rst) begin
            m_valid = 1'b1;
            m_err   = 1'b0;
            m_run   = 0;
            m_stall = 0;
            m_flush = 0;
            m_wait  = 0;
         end else if (m_valid) begin
            if (e_mode == 1 && !m_err) m_wait  = sat_inc(m_wait);
            if (e_mode == 2)           m_flush = sat_inc(m_flush);
            if (e_mode == 3)           m_stall = sat_inc(m_stall);
            if (!m_err) begin
               m_run = e_ms ? m_run + 1 : 0;
               if (m_run > int'(TO)) m_err = 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      IFID_rs1 = '0; IFID_rs2 = '0; IFID_use_rs1 = 1'b0; IFID_use_rs2 = 1'b0;
      IDEX_rd = '0; IDEX_MemRead = 1'b0; EX_branch_taken = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic set_lu_hazard();
      IDEX_MemRead = 1'b1; IDEX_rd = 5'd5; IFID_rs2 = 5'd5; IFID_use_rs2 = 1'b1;
   endtask

   int ready_pct;

   initial begin
      step(); step();
      // Reset: decode forced to advance even with a hazard present.
      set_lu_hazard();
      #2;
      check("rst pc_write", 32'(pc_write), 1);
      check("rst ID_flush", 32'(ID_flush), 0);
      check("rst freeze", 32'(freeze), 0);
      check("rst stall_cnt", 32'(stall_cnt), 0);
      check("rst mem_err", 32'(mem_err), 0);
      check("rst wait_cnt", 32'(wait_cnt), 0);

      // Load-use stall.
      step(); rst = 1'b0; #2;
      check("lu pc_write", 32'(pc_write), 0);
      check("lu IFID_write", 32'(IFID_write), 0);
      check("lu ID_flush", 32'(ID_flush), 1);
      step(); IDEX_MemRead = 1'b0; #2;
      check("lu after pc_write", 32'(pc_write), 1);
      check("lu after ID_flush", 32'(ID_flush), 0);
      check("lu stall_cnt", 32'(stall_cnt), 1);

      // x0 destination and unused source.
      step(); clear_inputs(); IDEX_MemRead = 1'b1; IFID_use_rs1 = 1'b1; #2;
      check("x0 ID_flush", 32'(ID_flush), 0);
      check("x0 pc_write", 32'(pc_write), 1);
      step(); IDEX_rd = 5'd7; IFID_rs1 = 5'd7; IFID_use_rs1 = 1'b0; #2;
      check("unused ID_flush", 32'(ID_flush), 0);
      check("unused stall_cnt", 32'(stall_cnt), 1);

      // Branch together with a load-use hazard.
      step(); IFID_use_rs1 = 1'b1; EX_branch_taken = 1'b1; #2;
      check("br IF_flush", 32'(IF_flush), 1);
      check("br ID_flush", 32'(ID_flush), 1);
      check("br pc_write", 32'(pc_write), 1);
      step(); clear_inputs(); #2;
      check("br flush_cnt", 32'(flush_cnt), 1);
      check("br stall_cnt", 32'(stall_cnt), 1);

      // Memory wait for 3 cycles with a branch ignored.
      for (int k = 0; k < 3; k++) begin
         step(); mem_req = 1'b1; mem_ready = 1'b0; EX_branch_taken = 1'b1; #2;
         check("mw freeze", 32'(freeze), 1);
         check("mw IF_flush", 32'(IF_flush), 0);
      end
      step(); mem_ready = 1'b1; EX_branch_taken = 1'b0; #2;
      check("mw done freeze", 32'(freeze), 0);
      check("mw wait_cnt", 32'(wait_cnt), 3);
      check("mw flush_cnt", 32'(flush_cnt), 1);
      step(); clear_inputs(); #2;

      // Timeout: error entered after the 5th consecutive wait cycle.
      for (int k = 0; k < 5; k++) begin
         step(); mem_req = 1'b1; mem_ready = 1'b0; #2;
         check("to freeze", 32'(freeze), 1);
         check("to mem_err early", 32'(mem_err), 0);
      end
      step(); mem_ready = 1'b1; #2;
      check("to mem_err", 32'(mem_err), 1);
      check("to freeze held", 32'(freeze), 1);
      check("to wait_cnt", 32'(wait_cnt), 8);
      step(); clear_inputs(); #2;
      check("to sticky", 32'(mem_err), 1);
      check("to wait_cnt frozen", 32'(wait_cnt), 8);
      step(); rst = 1'b1; #2;
      check("to rst freeze", 32'(freeze), 0);
      step(); #2;
      check("to rst mem_err", 32'(mem_err), 0);
      check("to rst wait_cnt", 32'(wait_cnt), 0);
      check("to rst flush_cnt", 32'(flush_cnt), 0);
      step(); rst = 1'b0; #2;
      check("to run freeze", 32'(freeze), 0);

      // Saturation: 20 load-use stalls on a 4-bit counter.
      for (int k = 0; k < 20; k++) begin
         step(); set_lu_hazard(); #2;
      end
      step(); clear_inputs(); #2;
      check("sat stall_cnt", 32'(stall_cnt), 15);

      // Randomized stimulus.
      ready_pct = 70;
      for (int i = 0; i < 4000; i++) begin
         step();
         if (i % 500 == 0) ready_pct = (ready_pct == 70) ? 15 : 70;
         rst             = ($urandom_range(0, 99) < 2);
         IFID_rs1        = REG_ADDR_WIDTH'($urandom_range(0, 3));
         IFID_rs2        = REG_ADDR_WIDTH'($urandom_range(0, 3));
         IFID_use_rs1    = ($urandom_range(0, 99) < 70);
         IFID_use_rs2    = ($urandom_range(0, 99) < 60);
         IDEX_rd         = REG_ADDR_WIDTH'($urandom_range(0, 3));
         IDEX_MemRead    = ($urandom_range(0, 99) < 50);
         EX_branch_taken = ($urandom_range(0, 99) < 20);
         mem_req         = ($urandom_range(0, 99) < 40);
         mem_ready       = ($urandom_range(0, 99) < ready_pct);
      end
      step(); rst = 1'b0; clear_inputs();
      @(negedge clk);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
